// File: rtl/ctrl_apb_master_pkg.sv
// Shared types for the control-plane APB master: response status codes and FSM states.
package ctrl_apb_master_pkg;

  typedef enum logic [1:0] {
    APB_OK      = 2'd0,
    APB_SLVERR  = 2'd1,
    APB_TIMEOUT = 2'd2,
    APB_DECERR  = 2'd3
  } apb_status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } ctrl_apb_state_e;

endpackage

// File: rtl/ctrl_apb_master_if.sv
// Command, response and APB signal bundle for ctrl_apb_master.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// valid must not depend on ready, and payload is stable while valid is high and not yet accepted.
interface ctrl_apb_master_if #(
  parameter int NUM_SLOTS = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_wdata;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [1:0]                  rsp_status;
  logic [DATA_W-1:0]           rsp_rdata;
  logic [NUM_SLOTS-1:0]        psel;
  logic                        penable;
  logic                        pwrite;
  logic [ADDR_W-1:0]           paddr;
  logic [DATA_W-1:0]           pwdata;
  logic [NUM_SLOTS*DATA_W-1:0] prdata;
  logic [NUM_SLOTS-1:0]        pready;
  logic [NUM_SLOTS-1:0]        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_status, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_status, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ctrl_apb_master.sv
// Control-plane APB3 master: one command at a time, slot decode from the address,
// per-transfer timeout, and a status+data response.
module ctrl_apb_master
  import ctrl_apb_master_pkg::*;
#(
  parameter int NUM_SLOTS   = 16,
  parameter int SLOT_BITS   = 5,
  parameter int SLOT_LSB    = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk_ctrl,
  input  logic            rst_ctrl,
  ctrl_apb_master_if.master bus,
  output ctrl_apb_state_e dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  ctrl_apb_state_e       state_q, state_d;
  logic [SLOT_BITS-1:0]  slot_q, slot_d;
  logic [NUM_SLOTS-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_status_e           status_q, status_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [SLOT_BITS-1:0]  cmd_slot;
  logic                  cmd_in_range;
  logic [NUM_SLOTS-1:0]  cmd_onehot;
  logic [DATA_W-1:0]     sel_prdata;
  logic                  sel_pready;
  logic                  sel_pslverr;

  assign cmd_slot     = bus.cmd_addr[SLOT_LSB +: SLOT_BITS];
  assign cmd_in_range = int'(cmd_slot) < NUM_SLOTS;

  // Decode and slave-return muxing; non-selected slots never reach the FSM.
  always_comb begin
    cmd_onehot  = '0;
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cmd_onehot[i] = (cmd_slot == SLOT_BITS'(i));
      if (slot_q == SLOT_BITS'(i)) begin
        sel_prdata  = bus.prdata[i*DATA_W +: DATA_W];
        sel_pready  = bus.pready[i];
        sel_pslverr = bus.pslverr[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          slot_d = cmd_slot;
          if (cmd_in_range) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
            psel_d   = cmd_onehot;
            state_d  = SETUP;
          end else begin
            // Out-of-range slot: answer directly, the APB bus stays untouched.
            rsp_valid_d = 1'b1;
            status_d    = APB_DECERR;
            rdata_d     = '0;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = CNT_W'(1);
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_pready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          status_d    = sel_pslverr ? APB_SLVERR : APB_OK;
          rdata_d     = (!pwrite_q && !sel_pslverr) ? sel_prdata : '0;
          cnt_d       = '0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          status_d    = APB_TIMEOUT;
          rdata_d     = '0;
          cnt_d       = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      status_q    <= APB_OK;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = status_q;
  assign bus.rsp_rdata  = rdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ctrl_apb_master.sv
// Directed bench for ctrl_apb_master: timing checks inline, responses checked by a
// scoreboard monitor against an expected queue.
module tb_ctrl_apb_master;
  import ctrl_apb_master_pkg::*;

  localparam int NS = 16;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 2 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ctrl_apb_state_e dbg_state;

  ctrl_apb_master_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ctrl_apb_master #(
    .NUM_SLOTS(NS), .SLOT_BITS(5), .SLOT_LSB(16), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(256)
  ) dut (
    .clk_ctrl (clk),
    .rst_ctrl (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response handshake is compared to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got status %0d rdata 0x%0h with nothing expected",
                 bus.rsp_status, bus.rsp_rdata);
      end else begin
        check("rsp", {bus.rsp_status, bus.rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready 0 required 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.prdata    = '0;
    bus.pready    = '0;
    bus.pslverr   = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_penable", 64'(bus.penable), 64'd0);
    check("rst_paddr", 64'(bus.paddr), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // 1: zero-wait read, slot 3
    bus.prdata[3*DW +: DW] = 32'hDEAD_BEEF;
    bus.pready[3] = 1'b1;
    exp_q.push_back({APB_OK, 32'hDEAD_BEEF});
    send_cmd(1'b0, 32'h0003_0010, 32'h0);
    check("t1_setup_psel", 64'(bus.psel), 64'h0008);
    check("t1_setup_penable", 64'(bus.penable), 64'd0);
    check("t1_setup_paddr", 64'(bus.paddr), 64'h0003_0010);
    check("t1_setup_pwrite", 64'(bus.pwrite), 64'd0);
    check("t1_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    tick();
    check("t1_access_penable", 64'(bus.penable), 64'd1);
    check("t1_access_psel", 64'(bus.psel), 64'h0008);
    tick();
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_psel", 64'(bus.psel), 64'd0);
    check("t1_rsp_penable", 64'(bus.penable), 64'd0);
    drain("t1_drain");
    bus.pready = '0;

    // 2: write slot 15, slave inserts 5 wait states
    exp_q.push_back({APB_OK, 32'h0});
    send_cmd(1'b1, 32'h000F_0004, 32'h0000_1234);
    check("t2_setup_psel", 64'(bus.psel), 64'h8000);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.penable) begin
        n++;
        check("t2_pwdata", 64'(bus.pwdata), 64'h1234);
        if (n == 6) bus.pready[15] = 1'b1;
      end
      tick();
      if (!bus.penable && n > 0) break;
    end
    check("t2_access_cycles", 64'(n), 64'd6);
    check("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    bus.pready = '0;
    drain("t2_drain");

    // 3: read slot 7, pready stuck low -> timeout after 256 ACCESS cycles
    exp_q.push_back({APB_TIMEOUT, 32'h0});
    bus.prdata[7*DW +: DW] = 32'h5555_AAAA;
    send_cmd(1'b0, 32'h0007_0000, 32'h0);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.penable) n++;
      tick();
      if (!bus.penable && n > 0) break;
    end
    check("t3_access_cycles", 64'(n), 64'd256);
    check("t3_psel_low", 64'(bus.psel), 64'd0);
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    drain("t3_drain");

    // 4: slot 20 is out of range -> DECERR without APB activity
    exp_q.push_back({APB_DECERR, 32'h0});
    send_cmd(1'b0, 32'h0014_0000, 32'h0);
    check("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t4_psel", 64'(bus.psel), 64'd0);
    check("t4_penable", 64'(bus.penable), 64'd0);
    drain("t4_drain");

    // 5: slave error on slot 0, response back-pressured for 10 cycles, slot 1 noise
    bus.rsp_ready  = 1'b0;
    bus.pready[0]  = 1'b1;
    bus.pslverr[0] = 1'b1;
    bus.prdata[0 +: DW] = 32'hFFFF_FFFF;
    exp_q.push_back({APB_SLVERR, 32'h0});
    send_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0001);
    check("t5_setup_psel", 64'(bus.psel), 64'h0001);
    for (int k = 0; k < 2; k++) begin
      bus.pready[1]  = ~bus.pready[1];
      bus.pslverr[1] = ~bus.pslverr[1];
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      check("t5_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("t5_hold_status", 64'(bus.rsp_status), 64'(APB_SLVERR));
      check("t5_hold_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("t5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      bus.pready[1]  = ~bus.pready[1];
      bus.pslverr[1] = ~bus.pslverr[1];
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t5_after_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.pready  = '0;
    bus.pslverr = '0;
    drain("t5_drain");

    // 6: reset during ACCESS aborts silently; next command completes
    send_cmd(1'b1, 32'h0002_0008, 32'h0BAD_F00D);
    tick();
    check("t6_in_access", 64'(bus.penable), 64'd1);
    rst = 1'b1;
    tick();
    check("t6_rst_psel", 64'(bus.psel), 64'd0);
    check("t6_rst_penable", 64'(bus.penable), 64'd0);
    check("t6_rst_pwrite", 64'(bus.pwrite), 64'd0);
    check("t6_rst_paddr", 64'(bus.paddr), 64'd0);
    check("t6_rst_pwdata", 64'(bus.pwdata), 64'd0);
    check("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.prdata[2*DW +: DW] = 32'hCAFE_F00D;
    bus.pready[2] = 1'b1;
    exp_q.push_back({APB_OK, 32'hCAFE_F00D});
    send_cmd(1'b0, 32'h0002_000C, 32'h0);
    check("t6_setup_psel", 64'(bus.psel), 64'h0004);
    drain("t6_drain");
    bus.pready = '0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
